// File: rtl/color_led_pkg.sv
// ============================================================================
// Module   : color_led_pkg
// Brief    : Shared matrix geometry and scan-state encoding for the LED scanner.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package color_led_pkg;

    localparam int NUM_COLS = 3;
    localparam int NUM_ROWS = 4;
    localparam int FRAME_W  = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/color_led_pwm.sv
// ============================================================================
// Module   : color_led_pwm
// Brief    : Row PWM generator; o_pwm_on is the duty state for the cycle after
//            the current edge, so the caller can register it straight into pins.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module color_led_pwm #(
    parameter int PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_clear,
    input  logic                i_run,
    input  logic [PWM_BITS-1:0] i_brightness,
    output logic                o_pwm_on
);

    logic [PWM_BITS-1:0] r_cnt;
    logic [PWM_BITS-1:0] r_bright;
    logic [PWM_BITS-1:0] w_cnt_next;
    logic [PWM_BITS-1:0] w_bright_next;

    // Look-ahead values: what counter/brightness will hold after this edge.
    assign w_cnt_next    = i_clear ? '0 : r_cnt + PWM_BITS'(1);
    assign w_bright_next = i_clear ? i_brightness : r_bright;
    assign o_pwm_on      = (w_cnt_next < w_bright_next) || (&w_bright_next);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_bright <= '0;
        end else if (i_clear || i_run) begin
            r_cnt    <= w_cnt_next;
            r_bright <= w_bright_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/color_led_scan_ctrl.sv
// ============================================================================
// Module   : color_led_scan_ctrl
// Brief    : Column scan scheduler with blanking, PWM rows and frame-boundary
//            double buffering for a 3x4 colour LED matrix.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module color_led_scan_ctrl
    import color_led_pkg::*;
#(
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 16,
    parameter int PWM_BITS     = 4
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic                i_enable,
    input  logic [FRAME_W-1:0]  i_frame_data,
    input  logic                i_frame_valid,
    output logic                o_frame_ready,
    input  logic [PWM_BITS-1:0] i_brightness,
    output logic [NUM_COLS-1:0] o_col_n,
    output logic [NUM_ROWS-1:0] o_row,
    output logic                o_frame_start
);

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int COL_W   = $clog2(NUM_COLS);

    localparam logic [CNT_W-1:0] c_dwell_last = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_blank_last = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [COL_W-1:0] c_last_col   = COL_W'(NUM_COLS - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_next;
    logic [COL_W-1:0]    r_col;
    logic [COL_W-1:0]    w_col_next;

    logic [FRAME_W-1:0]  r_active;
    logic [FRAME_W-1:0]  r_pending;
    logic                r_full;
    logic                w_accept;
    logic                w_boundary;

    logic                w_drive_next;
    logic                w_enter_drive;
    logic                w_pwm_on;
    logic [NUM_ROWS-1:0] w_col_rows [NUM_COLS];
    logic [NUM_COLS-1:0] w_col_n_next;
    logic [NUM_ROWS-1:0] w_row_next;
    logic                w_frame_start_next;

    logic [NUM_COLS-1:0] r_col_n;
    logic [NUM_ROWS-1:0] r_row;
    logic                r_frame_start;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_col         <= '0;
            r_col_n       <= '1;
            r_row         <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_col         <= w_col_next;
            r_col_n       <= w_col_n_next;
            r_row         <= w_row_next;
            r_frame_start <= w_frame_start_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + CNT_W'(1);
        w_col_next   = r_col;
        w_boundary   = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_next = '0;
                w_col_next = '0;
                if (i_enable) begin
                    w_state_next = BLANK;
                end
            end
            BLANK: begin
                if (r_cnt == c_blank_last) begin
                    w_state_next = DRIVE;
                    w_cnt_next   = '0;
                end
            end
            DRIVE: begin
                if (r_cnt == c_dwell_last) begin
                    w_cnt_next = '0;
                    w_boundary = (r_col == c_last_col);
                    if (!i_enable) begin
                        w_state_next = IDLE;
                        w_col_next   = '0;
                    end else begin
                        w_state_next = BLANK;
                        w_col_next   = (r_col == c_last_col) ? '0 : r_col + COL_W'(1);
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
                w_col_next   = '0;
            end
        endcase
    end

    // Accept never collides with a swap: a swap needs full, accept needs !full.
    assign w_accept      = i_frame_valid && !r_full;
    assign o_frame_ready = !r_full;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_pending <= '0;
            r_full    <= 1'b0;
            r_active  <= '0;
        end else begin
            if (w_accept) begin
                r_pending <= i_frame_data;
                r_full    <= 1'b1;
            end
            if (r_full && (w_boundary || (r_state == IDLE))) begin
                r_active <= r_pending;
                r_full   <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_COLS; g++) begin : g_col_rows
        assign w_col_rows[g] = r_active[g*NUM_ROWS +: NUM_ROWS];
    end

    assign w_drive_next  = (w_state_next == DRIVE);
    assign w_enter_drive = w_drive_next && (r_state != DRIVE);

    color_led_pwm #(
        .PWM_BITS     (PWM_BITS)
    ) u_pwm (
        .clk          (aclk),
        .rst          (areset),
        .i_clear      (w_enter_drive),
        .i_run        (w_drive_next && (r_state == DRIVE)),
        .i_brightness (i_brightness),
        .o_pwm_on     (w_pwm_on)
    );

    assign w_col_n_next       = w_drive_next ? ~(NUM_COLS'(1) << w_col_next) : '1;
    assign w_row_next         = w_drive_next ? (w_col_rows[w_col_next] & {NUM_ROWS{w_pwm_on}}) : '0;
    assign w_frame_start_next = w_enter_drive && (w_col_next == '0);

    assign o_col_n       = r_col_n;
    assign o_row         = r_row;
    assign o_frame_start = r_frame_start;

endmodule

`default_nettype wire

// File: tb/tb_color_led_scan_ctrl.sv
// ============================================================================
// Module   : tb_color_led_scan_ctrl
// Brief    : Directed self-checking bench for the colour LED scan scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_color_led_scan_ctrl;

    localparam int DWELL     = 32;
    localparam int BLANK     = 4;
    localparam int PWMB      = 4;
    localparam int COL_PER   = DWELL + BLANK;
    localparam int FRAME_PER = 3 * COL_PER;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        i_enable = 1'b0;
    logic [11:0] i_frame_data = '0;
    logic        i_frame_valid = 1'b0;
    logic        o_frame_ready;
    logic [3:0]  i_brightness = '0;
    logic [2:0]  o_col_n;
    logic [3:0]  o_row;
    logic        o_frame_start;

    int n_checks = 0;
    int n_errors = 0;

    always #5 aclk = ~aclk;

    color_led_scan_ctrl #(
        .DWELL_CYCLES (DWELL),
        .BLANK_CYCLES (BLANK),
        .PWM_BITS     (PWMB)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .i_enable      (i_enable),
        .i_frame_data  (i_frame_data),
        .i_frame_valid (i_frame_valid),
        .o_frame_ready (o_frame_ready),
        .i_brightness  (i_brightness),
        .o_col_n       (o_col_n),
        .o_row         (o_row),
        .o_frame_start (o_frame_start)
    );

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Expected {col_n, row, frame_start} p edges after the enable-sampling edge.
    function automatic logic [7:0] model(int p, logic [11:0] frame, logic [3:0] br);
        int q, col, d;
        logic [3:0] nib;
        logic [2:0] cn;
        logic on;
        q = p % COL_PER;
        col = (p / COL_PER) % 3;
        if (q < BLANK) return 8'b1110_0000;
        d = q - BLANK;
        on = ((d % 16) < int'(br)) || (br == 4'hF);
        nib = frame[col*4 +: 4];
        case (col)
            0:       cn = 3'b110;
            1:       cn = 3'b101;
            default: cn = 3'b011;
        endcase
        return {cn, (on ? nib : 4'h0), (q == BLANK && col == 0)};
    endfunction

    task automatic start_scan(input logic [11:0] frame, input logic [3:0] br);
        areset = 1'b1;
        i_enable = 1'b0;
        i_frame_valid = 1'b0;
        tick();
        tick();
        areset = 1'b0;
        i_brightness = br;
        i_frame_data = frame;
        i_frame_valid = 1'b1;
        tick();
        i_frame_valid = 1'b0;
        tick();
        i_enable = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [8:0] obs;
        areset = 1'b1;
        i_enable = 1'b0;
        i_frame_valid = 1'b0;
        tick();
        tick();
        areset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            obs = {o_col_n, o_row, o_frame_ready, o_frame_start};
            n_checks++;
            if (obs !== 9'b111_0000_1_0) begin
                n_errors++;
                $display("FAIL reset_idle cycle %0d: got %b expected %b", i, obs, 9'b111_0000_1_0);
            end
            tick();
        end
    endtask

    task automatic test_scan();
        logic [7:0] obs, exp;
        int starts;
        areset = 1'b1;
        tick();
        areset = 1'b0;
        i_brightness = 4'hF;
        i_frame_data = 12'hA5C;
        i_frame_valid = 1'b1;
        tick();
        i_frame_valid = 1'b0;
        n_checks++;
        if (o_frame_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL ready_after_accept: got %b expected 0", o_frame_ready);
        end
        tick();
        n_checks++;
        if (o_frame_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL ready_after_idle_swap: got %b expected 1", o_frame_ready);
        end
        i_enable = 1'b1;
        tick();
        starts = 0;
        for (int p = 0; p < FRAME_PER + 10; p++) begin
            if (p != 0) tick();
            obs = {o_col_n, o_row, o_frame_start};
            exp = model(p, 12'hA5C, 4'hF);
            n_checks++;
            if (obs !== exp) begin
                n_errors++;
                $display("FAIL scan p=%0d: got %b expected %b", p, obs, exp);
            end
            if ((p == 4 && obs !== 8'hD9) || (p == 44 && obs !== 8'hAA) || (p == 80 && obs !== 8'h74)) begin
                n_errors++;
                $display("FAIL scan_column_vector p=%0d: got %h", p, obs);
            end
            if (p == 4 || p == 44 || p == 80) n_checks++;
            if (o_frame_start === 1'b1) starts++;
        end
        n_checks++;
        if (starts != 2) begin
            n_errors++;
            $display("FAIL frame_start_count: got %0d expected 2", starts);
        end
    endtask

    task automatic test_pwm();
        logic [7:0] obs, exp;
        int ons, lit;
        start_scan(12'hFFF, 4'd4);
        ons = 0;
        for (int p = 0; p < FRAME_PER; p++) begin
            if (p != 0) tick();
            obs = {o_col_n, o_row, o_frame_start};
            exp = model(p, 12'hFFF, 4'd4);
            n_checks++;
            if (obs !== exp) begin
                n_errors++;
                $display("FAIL pwm4 p=%0d: got %b expected %b", p, obs, exp);
            end
            if (p >= BLANK && p < COL_PER && o_row === 4'hF) ons++;
        end
        n_checks++;
        if (ons != 8) begin
            n_errors++;
            $display("FAIL pwm4_on_count: got %0d expected 8", ons);
        end
        start_scan(12'hFFF, 4'd0);
        lit = 0;
        for (int p = 0; p < FRAME_PER; p++) begin
            if (p != 0) tick();
            obs = {o_col_n, o_row, o_frame_start};
            exp = model(p, 12'hFFF, 4'd0);
            n_checks++;
            if (obs !== exp) begin
                n_errors++;
                $display("FAIL pwm0 p=%0d: got %b expected %b", p, obs, exp);
            end
            if (o_row !== 4'h0) lit++;
        end
        n_checks++;
        if (lit != 0) begin
            n_errors++;
            $display("FAIL pwm0_dark: got %0d lit cycles expected 0", lit);
        end
    endtask

    task automatic test_frame_swap();
        logic [7:0] obs, exp;
        logic rdy_exp;
        start_scan(12'hA5C, 4'hF);
        for (int p = 0; p < 3 * FRAME_PER; p++) begin
            if (p != 0) tick();
            obs = {o_col_n, o_row, o_frame_start};
            exp = model(p, (p < FRAME_PER) ? 12'hA5C : 12'h123, 4'hF);
            rdy_exp = !(p >= 51 && p < FRAME_PER);
            n_checks++;
            if (obs !== exp || o_frame_ready !== rdy_exp) begin
                n_errors++;
                $display("FAIL swap p=%0d: got %b ready %b expected %b ready %b", p, obs, o_frame_ready, exp, rdy_exp);
            end
            if ((p == 112 && obs !== 8'hC7) || (p == 292 && obs !== 8'h62)) begin
                n_errors++;
                $display("FAIL swap_vector p=%0d: got %h", p, obs);
            end
            if (p == 112 || p == 292) n_checks++;
            if (p == 50) begin
                i_frame_valid = 1'b1;
                i_frame_data = 12'h123;
            end else if (p == 51) begin
                i_frame_data = 12'h777;
            end else if (p == 100) begin
                i_frame_valid = 1'b0;
            end
        end
    endtask

    task automatic test_disable();
        logic [7:0] obs, exp;
        start_scan(12'hA5C, 4'hF);
        for (int p = 0; p < 80; p++) begin
            if (p != 0) tick();
            obs = {o_col_n, o_row, o_frame_start};
            exp = (p < 72) ? model(p, 12'hA5C, 4'hF) : 8'b1110_0000;
            n_checks++;
            if (obs !== exp) begin
                n_errors++;
                $display("FAIL disable p=%0d: got %b expected %b", p, obs, exp);
            end
            if (p == 50) i_enable = 1'b0;
        end
        i_enable = 1'b1;
        for (int p = 0; p < 41; p++) begin
            tick();
            obs = {o_col_n, o_row, o_frame_start};
            exp = model(p, 12'hA5C, 4'hF);
            n_checks++;
            if (obs !== exp) begin
                n_errors++;
                $display("FAIL reenable p=%0d: got %b expected %b", p, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [8:0] rst_obs;
        logic [7:0] obs, exp;
        start_scan(12'hA5C, 4'hF);
        for (int p = 1; p <= 55; p++) begin
            tick();
            if (p == 50) begin
                i_frame_valid = 1'b1;
                i_frame_data = 12'h123;
            end else if (p == 51) begin
                i_frame_valid = 1'b0;
                n_checks++;
                if (o_frame_ready !== 1'b0) begin
                    n_errors++;
                    $display("FAIL mid_accept: ready %b expected 0", o_frame_ready);
                end
            end
        end
        areset = 1'b1;
        tick();
        areset = 1'b0;
        rst_obs = {o_col_n, o_row, o_frame_ready, o_frame_start};
        n_checks++;
        if (rst_obs !== 9'b111_0000_1_0) begin
            n_errors++;
            $display("FAIL reset_mid_values: got %b expected %b", rst_obs, 9'b111_0000_1_0);
        end
        for (int p = 0; p < FRAME_PER + 10; p++) begin
            tick();
            obs = {o_col_n, o_row, o_frame_start};
            exp = model(p, 12'h000, 4'hF);
            n_checks++;
            if (obs !== exp || o_frame_ready !== 1'b1) begin
                n_errors++;
                $display("FAIL after_reset p=%0d: got %b ready %b expected %b ready 1", p, obs, o_frame_ready, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_pwm();
        test_frame_swap();
        test_disable();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
